// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multicycle MIPS controller: state encodings, opcodes,
// datapath select codes and the control-word struct.
package mips_ctrl_pkg;

    localparam logic [3:0] ST_FETCH  = 4'd0;
    localparam logic [3:0] ST_DECODE = 4'd1;
    localparam logic [3:0] ST_MEMADR = 4'd2;
    localparam logic [3:0] ST_MEMRD  = 4'd3;
    localparam logic [3:0] ST_MEMWB  = 4'd4;
    localparam logic [3:0] ST_MEMWR  = 4'd5;
    localparam logic [3:0] ST_RTEX   = 4'd6;
    localparam logic [3:0] ST_ALUWB  = 4'd7;
    localparam logic [3:0] ST_BRANCH = 4'd8;
    localparam logic [3:0] ST_ADDIEX = 4'd9;
    localparam logic [3:0] ST_ADDIWB = 4'd10;
    localparam logic [3:0] ST_JUMP   = 4'd11;
    localparam logic [3:0] ST_ILL    = 4'd12;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSL2 = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Moore output decoder: current state (plus mem_ready in FETCH) -> control word.
// JUMP_EN enables the jump control word; without it the JUMP state decodes to all-zero.
module mc_ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  logic [3:0] state,
    input  logic       mem_ready,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            ST_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALU_ADD;
                ctrl.pc_src    = PC_ALU;
                // IR and PC only load on the cycle the instruction word arrives
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            ST_DECODE: ctrl.alu_src_b = SRCB_IMMSL2;
            ST_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            ST_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            ST_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            ST_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
            end
            ST_RTEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_RT;
                ctrl.alu_op    = ALU_FUNCT;
            end
            ST_ALUWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            ST_BRANCH: begin
                ctrl.pc_write_cond = 1'b1;
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_src        = PC_ALUOUT;
            end
            ST_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            ST_ADDIWB: ctrl.reg_write = 1'b1;
`ifdef JUMP_EN
            ST_JUMP: begin
                ctrl.pc_write = 1'b1;
                ctrl.pc_src   = PC_JUMP;
            end
`endif
            ST_ILL: ctrl.illegal = 1'b1;
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS main controller: state register and next-state logic; outputs
// come from mc_ctrl_decode. Define JUMP_EN to support opcode 000010 (j).
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 6,
    parameter int ALUOP_W  = 2,
    parameter int STATE_W  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic                i_or_d,
    output logic                mem_read,
    output logic                mem_write,
    output logic                ir_write,
    output logic                mem_to_reg,
    output logic                reg_dst,
    output logic                reg_write,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [ALUOP_W-1:0]  alu_op,
    output logic [1:0]          pc_src,
    output logic [STATE_W-1:0]  state,
    output logic                illegal
);

    logic [3:0] state_q;
    logic [3:0] state_d;
    logic [5:0] op;
    ctrl_t      ctrl;

    assign op = 6'(opcode);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = ST_FETCH;
        case (state_q)
            ST_FETCH:  state_d = mem_ready ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = ST_MEMADR;
                    OP_RTYPE:     state_d = ST_RTEX;
                    OP_BEQ:       state_d = ST_BRANCH;
                    OP_ADDI:      state_d = ST_ADDIEX;
`ifdef JUMP_EN
                    OP_J:         state_d = ST_JUMP;
`endif
                    default:      state_d = ST_ILL;
                endcase
            end
            ST_MEMADR: state_d = (op == OP_SW) ? ST_MEMWR : ST_MEMRD;
            ST_MEMRD:  state_d = mem_ready ? ST_MEMWB : ST_MEMRD;
            ST_MEMWR:  state_d = mem_ready ? ST_FETCH : ST_MEMWR;
            ST_RTEX:   state_d = ST_ALUWB;
            ST_ADDIEX: state_d = ST_ADDIWB;
            default:   state_d = ST_FETCH;
        endcase
    end

    // Reset forces FETCH asynchronously; gating mem_ready keeps FETCH's
    // ir_write/pc_write low while reset is held.
    mc_ctrl_decode u_decode (
        .state     (state_q),
        .mem_ready (mem_ready & rst_n),
        .ctrl      (ctrl)
    );

    assign pc_write      = ctrl.pc_write;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign i_or_d        = ctrl.i_or_d;
    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign ir_write      = ctrl.ir_write;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign reg_dst       = ctrl.reg_dst;
    assign reg_write     = ctrl.reg_write;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign alu_op        = ALUOP_W'(ctrl.alu_op);
    assign pc_src        = ctrl.pc_src;
    assign illegal       = ctrl.illegal;
    assign state         = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: per-cycle expected control words
// derived from the state table, compared through a scoreboard queue.
module tb_multicycle_control;

    logic       clk;
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal;
    logic [1:0] alu_src_b, alu_op, pc_src;
    logic [3:0] state;

    logic [20:0] exp_q[$];
    int          n_total;
    int          n_bad;

    multicycle_control dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .mem_to_reg    (mem_to_reg),
        .reg_dst       (reg_dst),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_src        (pc_src),
        .state         (state),
        .illegal       (illegal)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {state, pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
    //  mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_src, illegal}
    function automatic logic [20:0] exp_word(input logic [3:0] st, input logic rdy);
        logic pw, pwc, iod, mr, mw, irw, m2r, rd, rw, a, ill;
        logic [1:0] b, aop, pcs;
        {pw, pwc, iod, mr, mw, irw, m2r, rd, rw, a, ill} = '0;
        b = 2'b00; aop = 2'b00; pcs = 2'b00;
        case (st)
            4'd0:  begin mr = 1; b = 2'b01; irw = rdy; pw = rdy; end
            4'd1:  b = 2'b11;
            4'd2:  begin a = 1; b = 2'b10; end
            4'd3:  begin mr = 1; iod = 1; end
            4'd4:  begin rw = 1; m2r = 1; end
            4'd5:  begin mw = 1; iod = 1; end
            4'd6:  begin a = 1; aop = 2'b10; end
            4'd7:  begin rw = 1; rd = 1; end
            4'd8:  begin pwc = 1; a = 1; aop = 2'b01; pcs = 2'b01; end
            4'd9:  begin a = 1; b = 2'b10; end
            4'd10: rw = 1;
            4'd11: begin pw = 1; pcs = 2'b10; end
            4'd12: ill = 1;
            default: ;
        endcase
        return {st, pw, pwc, iod, mr, mw, irw, m2r, rd, rw, a, b, aop, pcs, ill};
    endfunction

    function automatic logic [20:0] obs_word();
        return {state, pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_src, illegal};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Called just after a falling edge: drive mem_ready, score this cycle, wait a cycle.
    task automatic step(input logic [3:0] st, input logic rdy);
        logic [20:0] e;
        mem_ready = rdy;
        exp_q.push_back(exp_word(st, rdy));
        #1;
        e = exp_q.pop_front();
        check($sformatf("cyc_st%0d", st), 32'(obs_word()), 32'(e));
        check("rd_wr_excl", 32'(mem_read & mem_write), 32'd0);
        @(negedge clk);
    endtask

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic run_instr(input logic [5:0] op, input int fstall, input int mstall);
        opcode = 6'($urandom);
        for (int i = 0; i < fstall; i++) step(4'd0, 1'b0);
        step(4'd0, 1'b1);
        opcode = op;
        step(4'd1, rnd_bit());
        case (op)
            6'b100011: begin
                step(4'd2, rnd_bit());
                opcode = 6'($urandom);
                for (int i = 0; i < mstall; i++) step(4'd3, 1'b0);
                step(4'd3, 1'b1);
                step(4'd4, rnd_bit());
            end
            6'b101011: begin
                step(4'd2, rnd_bit());
                opcode = 6'($urandom);
                for (int i = 0; i < mstall; i++) step(4'd5, 1'b0);
                step(4'd5, 1'b1);
            end
            6'b000000: begin
                opcode = 6'($urandom);
                step(4'd6, rnd_bit());
                step(4'd7, rnd_bit());
            end
            6'b000100: step(4'd8, rnd_bit());
            6'b001000: begin
                step(4'd9, rnd_bit());
                step(4'd10, rnd_bit());
            end
`ifdef JUMP_EN
            6'b000010: step(4'd11, rnd_bit());
`endif
            default:   step(4'd12, rnd_bit());
        endcase
    endtask

    logic [5:0] op_tab[6];

    initial begin
        n_total   = 0;
        n_bad     = 0;
        rst_n     = 1'b0;
        mem_ready = 1'b1;
        opcode    = 6'b000000;
        op_tab    = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};

        #3;
        check("reset_word", 32'(obs_word()), 32'(exp_word(4'd0, 1'b0)));
        @(negedge clk);
        rst_n = 1'b1;

        run_instr(6'b000000, 0, 0);  // R-type: 0,1,6,7
        run_instr(6'b100011, 0, 3);  // lw with MEMRD stalls
        run_instr(6'b101011, 2, 0);  // sw with FETCH stalls
        run_instr(6'b000100, 0, 0);  // beq
        run_instr(6'b001000, 0, 0);  // addi
        run_instr(6'b111111, 0, 0);  // illegal
        run_instr(6'b000010, 0, 0);  // j (or illegal without JUMP_EN)
        run_instr(6'b000000, 1, 0);

        for (int k = 0; k < 12; k++)
            run_instr(op_tab[$urandom_range(0, 5)], $urandom_range(0, 2), $urandom_range(0, 2));

        // asynchronous reset in the middle of a load
        opcode = 6'b100011;
        step(4'd0, 1'b1);
        step(4'd1, 1'b1);
        step(4'd2, 1'b0);
        step(4'd3, 1'b0);
        mem_ready = 1'b1;
        rst_n     = 1'b0;
        #1;
        check("async_rst", 32'(obs_word()), 32'(exp_word(4'd0, 1'b0)));
        @(negedge clk);
        check("rst_hold", 32'(obs_word()), 32'(exp_word(4'd0, 1'b0)));
        rst_n = 1'b1;
        run_instr(6'b000100, 0, 0);
        run_instr(6'b100011, 0, 1);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter OPCODE_W, default 6, opcode field width.
REQ-002 SHALL have parameter ALUOP_W, default 2, ALU-operation code width; values above 2 zero-extend alu_op.
REQ-003 SHALL have parameter STATE_W, default 4, width of the state debug output.
REQ-004 SHALL have ports, clock and reset first:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  OPCODE_W  instruction opcode, valid from the DECODE cycle.
- mem_ready  in  1  memory access completes this cycle.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load when ALU zero.
- i_or_d  out  1  memory address: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  instruction register load.
- mem_to_reg  out  1  write-back: 0 = ALUOut, 1 = MDR.
- reg_dst  out  1  destination: 0 = rt, 1 = rd.
- reg_write  out  1  register file write.
- alu_src_a  out  1  0 = PC, 1 = rs.
- alu_src_b  out  2  00 = rt, 01 = const 4, 10 = sign-extended imm, 11 = imm<<2.
- alu_op  out  ALUOP_W  00 = add, 01 = sub, 10 = funct-decoded.
- pc_src  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- state  out  STATE_W  current state encoding.
- illegal  out  1  one-cycle pulse, unsupported opcode.

Function
REQ-005 SHALL be a Moore FSM; all outputs are decoded from the current state only, except ir_write/pc_write in FETCH (REQ-007).
REQ-006 SHALL use states and encodings FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTEX=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11, ILL=12.
REQ-007 SHALL in FETCH assert mem_read, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00; assert ir_write and pc_write only while mem_ready=1; stay in FETCH while mem_ready=0.
REQ-008 SHALL in DECODE drive alu_src_a=0, alu_src_b=11, alu_op=00, then branch on opcode: 100011/101011 -> MEMADR, 000000 -> RTEX, 000100 -> BRANCH, 001000 -> ADDIEX, 000010 -> JUMP (REQ-016), else -> ILL.
REQ-009 SHALL in MEMADR drive alu_src_a=1, alu_src_b=10, alu_op=00; next MEMRD for lw, MEMWR for sw.
REQ-010 SHALL in MEMRD assert mem_read, i_or_d=1; hold until mem_ready=1, then MEMWB.
REQ-011 SHALL in MEMWB assert reg_write, mem_to_reg=1, reg_dst=0; next FETCH.
REQ-012 SHALL in MEMWR assert mem_write, i_or_d=1; hold until mem_ready=1, then FETCH.
REQ-013 SHALL in RTEX drive alu_src_a=1, alu_src_b=00, alu_op=10, then ALUWB (reg_write, reg_dst=1, mem_to_reg=0), then FETCH.
REQ-014 SHALL in BRANCH assert pc_write_cond, alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01; next FETCH.
REQ-015 SHALL in ADDIEX drive alu_src_a=1, alu_src_b=10, alu_op=00, then ADDIWB (reg_write, reg_dst=0, mem_to_reg=0), then FETCH.
REQ-016 SHALL in JUMP assert pc_write, pc_src=10; next FETCH.
REQ-017 SHALL in ILL assert illegal for exactly one cycle, no register/memory/PC write; next FETCH.
REQ-018 SHALL deassert every output not listed for a state (0 / all-zero); mem_read and mem_write are never both 1.
REQ-019 SHALL ignore opcode outside DECODE and MEMADR; mem_ready outside FETCH/MEMRD/MEMWR has no effect.
REQ-020 SHALL use cycle counts with mem_ready=1 throughout: R-type 4, lw 5, sw 4, beq 3, addi 4, j 3.

Reset
REQ-021 SHALL on rst_n=0, immediately and independent of clk, enter FETCH, clear all write enables and illegal, and drive state=0.
REQ-022 SHALL on reset assertion mid-instruction abandon it; the first fetch follows the first rising edge after rst_n returns to 1.

Configuration
REQ-023 SHALL, with JUMP_EN defined, implement opcode 000010 via JUMP; without JUMP_EN, opcode 000010 goes to ILL and state JUMP is unreachable, pc_src never 10.

Structure
REQ-024 SHALL place state encodings, opcode constants and alu_op/alu_src_b/pc_src codes in shared package mips_ctrl_pkg.
REQ-025 SHALL split output decoding into sub-module mc_ctrl_decode (state, mem_ready -> control word); the top holds the state register and next-state logic.

Verification
REQ-026 SHALL cover: R-type opcode 000000, mem_ready=1 -> states 0,1,6,7; reg_write=1 and reg_dst=1 in cycle 4 only.
REQ-027 SHALL cover: lw 100011, mem_ready low 3 cycles in MEMRD -> state 3 held 4 cycles, then 4 with mem_to_reg=1.
REQ-028 SHALL cover: sw 101011 with mem_ready low 2 cycles in FETCH -> ir_write/pc_write absent until mem_ready=1, then 0,1,2,5 with mem_write=1, reg_write never 1.
REQ-029 SHALL cover: beq 000100 -> 3 cycles, pc_write_cond=1, alu_op=01 in state 8; opcode 111111 -> illegal pulses one cycle in state 12, returns to 0.
REQ-030 SHALL cover: rst_n low mid-MEMRD -> outputs cleared and state=0 before next clk edge; opcode 000010 -> state 11, pc_src=10 with JUMP_EN, illegal=1 without.
